// File: rtl/freq_div_prog.sv
// Programmable clock-enable divider: registered divided waveform plus period strobe, with a
// valid/ready divisor port whose value takes effect only at a period boundary.
module freq_div_prog #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MinDiv = WIDTH'(2);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic             xfer;
  logic             wrap;

  assign xfer = cfg_valid & ~pend_valid_q;
  assign wrap = en & (count_q == div_q - 1'b1);

  always_comb begin
    count_d      = count_q;
    div_d        = div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    tick_d       = 1'b0;
    cfg_err_d    = 1'b0;

    if (sync_clr) begin
      count_d = '0;
      if (pend_valid_q) begin
        div_d        = pend_div_q;
        pend_valid_d = 1'b0;
      end
    end else if (pend_valid_q && !en) begin
      // Frozen counter: restart the period immediately under the new divisor.
      count_d      = '0;
      div_d        = pend_div_q;
      pend_valid_d = 1'b0;
    end else if (en) begin
      if (wrap) begin
        count_d = '0;
        tick_d  = 1'b1;
        if (pend_valid_q) begin
          div_d        = pend_div_q;
          pend_valid_d = 1'b0;
        end
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    // A transfer needs an empty slot, so it never collides with an apply above.
    if (xfer) begin
      if (cfg_div >= MinDiv) begin
        pend_valid_d = 1'b1;
        pend_div_d   = cfg_div;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    // High for the last floor(N/2) counts of each period.
    clk_out_d = (count_d >= (div_d - (div_d >> 1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      div_q        <= DefDiv;
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      count_q      <= count_d;
      div_q        <= div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg_ready = ~pend_valid_q;
  assign cfg_err   = cfg_err_q;
  assign clk_out   = clk_out_q;
  assign tick      = tick_q;
  assign cur_div   = div_q;

endmodule
